// File: rtl/cam_stream_gen.sv
// cam_stream_gen: OV7670-style parallel stream source (pclk, v_sync, h_ref, data)
// carrying RGB565 colour bars, for exercising the capture path without a sensor.
// Optional build macro CAM_STREAM_SCROLL_EN: bar pattern shifts one position per
// completed frame (offset taken from frame_count[2:0]).
module cam_stream_gen #(
    parameter int unsigned H_PIXELS    = 640,
    parameter int unsigned V_LINES     = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic       clk_25,
    input  logic       reset_n,
    input  logic       enable,
    output logic       pclk,
    output logic       v_sync,
    output logic       h_ref,
    output logic [7:0] data_out,
    output logic       frame_done,
    output logic [7:0] frame_count
);

    localparam int unsigned LINE_SLOTS = 2 * H_PIXELS + H_BLANK;
    localparam int unsigned ACT_SLOTS  = 2 * H_PIXELS;
    localparam int unsigned BAR_W      = H_PIXELS / 8;
    localparam int unsigned MAX_VS_VB  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int unsigned MAX_VL_VF  = (V_LINES > V_FRONT) ? V_LINES : V_FRONT;
    localparam int unsigned LINE_MAX   = (MAX_VS_VB > MAX_VL_VF) ? MAX_VS_VB : MAX_VL_VF;
    localparam int unsigned SLOT_W     = $clog2(LINE_SLOTS);
    localparam int unsigned LINE_W     = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(LINE_SLOTS - 1);
    localparam logic [SLOT_W-1:0] ACT_END     = SLOT_W'(ACT_SLOTS);
    localparam logic [SLOT_W-1:0] BAR_DIV     = SLOT_W'(BAR_W);
    localparam logic [LINE_W-1:0] VSYNC_LAST  = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] VBACK_LAST  = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] ACTIVE_LAST = LINE_W'(V_LINES - 1);
    localparam logic [LINE_W-1:0] VFRONT_LAST = LINE_W'(V_FRONT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                pclk_q, pclk_d;
    logic                v_sync_q, v_sync_d;
    logic                h_ref_q, h_ref_d;
    logic [7:0]          data_q, data_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          frame_count_q, frame_count_d;

    logic                line_end;
    logic                seg_end;
    logic [LINE_W-1:0]   seg_last;
    logic [SLOT_W-1:0]   px_x;
    logic [2:0]          bar_base;
    logic [2:0]          bar_idx;
    logic [15:0]         rgb;

    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 16'hFFFF;  // white
            3'd1:    bar_rgb = 16'hFFE0;  // yellow
            3'd2:    bar_rgb = 16'h07FF;  // cyan
            3'd3:    bar_rgb = 16'h07E0;  // green
            3'd4:    bar_rgb = 16'hF81F;  // magenta
            3'd5:    bar_rgb = 16'hF800;  // red
            3'd6:    bar_rgb = 16'h001F;  // blue
            default: bar_rgb = 16'h0000;  // black
        endcase
    endfunction

    // Next-state, timing counters and the outputs of the upcoming slot.
    // Everything except pclk advances only on the clk_25 edge where pclk falls,
    // and the outputs are derived from the next position so they are registered.
    always_comb begin
        pclk_d        = ~pclk_q;
        state_d       = state_q;
        slot_d        = slot_q;
        line_d        = line_q;
        v_sync_d      = v_sync_q;
        h_ref_d       = h_ref_q;
        data_d        = data_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        px_x          = '0;
        bar_base      = '0;
        bar_idx       = '0;
        rgb           = '0;

        line_end = (slot_q == SLOT_LAST);
        case (state_q)
            S_VSYNC:  seg_last = VSYNC_LAST;
            S_VBACK:  seg_last = VBACK_LAST;
            S_ACTIVE: seg_last = ACTIVE_LAST;
            S_VFRONT: seg_last = VFRONT_LAST;
            default:  seg_last = '0;
        endcase
        seg_end = line_end && (line_q == seg_last);

        if (pclk_q) begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_VSYNC;
                        slot_d  = '0;
                        line_d  = '0;
                    end
                end
                default: begin
                    if (!line_end) begin
                        slot_d = slot_q + 1'b1;
                    end else begin
                        slot_d = '0;
                        if (!seg_end) begin
                            line_d = line_q + 1'b1;
                        end else begin
                            line_d = '0;
                            case (state_q)
                                S_VSYNC:  state_d = S_VBACK;
                                S_VBACK:  state_d = S_ACTIVE;
                                S_ACTIVE: state_d = S_VFRONT;
                                default: begin
                                    // end of V_FRONT: frame boundary, enable sampled here
                                    state_d       = enable ? S_VSYNC : S_IDLE;
                                    frame_done_d  = 1'b1;
                                    frame_count_d = frame_count_q + 8'd1;
                                end
                            endcase
                        end
                    end
                end
            endcase

            px_x     = slot_d >> 1;
            bar_base = 3'(px_x / BAR_DIV);
`ifdef CAM_STREAM_SCROLL_EN
            bar_idx  = bar_base + frame_count_q[2:0];
`else
            bar_idx  = bar_base;
`endif
            rgb      = bar_rgb(bar_idx);

            v_sync_d = (state_d == S_VSYNC);
            h_ref_d  = (state_d == S_ACTIVE) && (slot_d < ACT_END);
            data_d   = h_ref_d ? (slot_d[0] ? rgb[7:0] : rgb[15:8]) : '0;
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            slot_q        <= '0;
            line_q        <= '0;
            pclk_q        <= 1'b0;
            v_sync_q      <= 1'b0;
            h_ref_q       <= 1'b0;
            data_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            line_q        <= line_d;
            pclk_q        <= pclk_d;
            v_sync_q      <= v_sync_d;
            h_ref_q       <= h_ref_d;
            data_q        <= data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pclk        = pclk_q;
    assign v_sync      = v_sync_q;
    assign h_ref       = h_ref_q;
    assign data_out    = data_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen with a tiny frame geometry:
// L = 19 slots per line, 5 line periods per frame, 190 clk_25 per frame.
module tb_cam_stream_gen;

    localparam int L_SLOTS  = 19;
    localparam int F_CYCLES = 190;

    logic       clk_25 = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       pclk;
    logic       v_sync;
    logic       h_ref;
    logic [7:0] data_out;
    logic       frame_done;
    logic [7:0] frame_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] first_b0;
    logic [7:0] first_b1;

    // Hand-written RGB565 words for bars 0..7
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    cam_stream_gen #(
        .H_PIXELS   (8),
        .V_LINES    (2),
        .H_BLANK    (3),
        .VSYNC_LINES(1),
        .V_BACK     (1),
        .V_FRONT    (1)
    ) dut (
        .clk_25     (clk_25),
        .reset_n    (reset_n),
        .enable     (enable),
        .pclk       (pclk),
        .v_sync     (v_sync),
        .h_ref      (h_ref),
        .data_out   (data_out),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    always #5 clk_25 = ~clk_25;

    // Follow one whole frame from its first VSYNC slot, checking every slot
    // against the hand-derived timeline, then the frame boundary afterwards.
    task automatic capture_frame(input int exp_fc, input int drop_at, input logic exp_next);
        int waited = 0;
        int vs_cnt = 0;
        int hr_pulses = 0;
        logic hr_prev = 1'b0;
        int k, s, ln;
        logic [2:0] off;
        logic [15:0] w;
        logic ev, eh;
        logic [7:0] eb;
        while (v_sync !== 1'b1 && waited < 400) begin
            @(negedge clk_25);
            waited++;
        end
        checks++;
        if (v_sync !== 1'b1) begin
            failures++;
            $display("FAIL vsync_start fc=%0d: v_sync=%b required 1 within 400 cycles", exp_fc, v_sync);
            return;
        end
`ifdef CAM_STREAM_SCROLL_EN
        off = 3'(exp_fc - 1);
`else
        off = 3'd0;
`endif
        checks++;
        if (frame_count !== 8'(exp_fc - 1)) begin
            failures++;
            $display("FAIL count_in_frame: frame_count=%0d required %0d", frame_count, exp_fc - 1);
        end
        for (int i = 0; i <= F_CYCLES; i++) begin
            if (i > 0) @(negedge clk_25);
            if (i < F_CYCLES) begin
                checks++;
                if (pclk !== ((i % 2) == 1)) begin
                    failures++;
                    $display("FAIL pclk_phase i=%0d: pclk=%b required %b", i, pclk, (i % 2) == 1);
                end
                if (i > 0) begin
                    checks++;
                    if (frame_done !== 1'b0) begin
                        failures++;
                        $display("FAIL frame_done_mid i=%0d: frame_done=%b required 0", i, frame_done);
                    end
                end
                if ((i % 2) == 0) begin
                    k  = i / 2;
                    ln = k / L_SLOTS;
                    s  = k % L_SLOTS;
                    ev = (ln == 0);
                    eh = (ln == 2 || ln == 3) && (s < 16);
                    w  = bars[3'(s / 2) + off];
                    eb = eh ? (((s % 2) == 0) ? w[15:8] : w[7:0]) : 8'h00;
                    checks++;
                    if ({v_sync, h_ref, data_out} !== {ev, eh, eb}) begin
                        failures++;
                        $display("FAIL slot fc=%0d k=%0d: vs/hr/data=%b/%b/%h required %b/%b/%h",
                                 exp_fc, k, v_sync, h_ref, data_out, ev, eh, eb);
                    end
                    if (v_sync === 1'b1) vs_cnt++;
                    if (h_ref === 1'b1 && !hr_prev) hr_pulses++;
                    hr_prev = (h_ref === 1'b1);
                    if (ln == 2 && s == 0) first_b0 = data_out;
                    if (ln == 2 && s == 1) first_b1 = data_out;
                end
            end else begin
                checks++;
                if (frame_done !== 1'b1 || frame_count !== 8'(exp_fc)) begin
                    failures++;
                    $display("FAIL frame_end fc=%0d: frame_done=%b frame_count=%0d required 1 and %0d",
                             exp_fc, frame_done, frame_count, exp_fc);
                end
                checks++;
                if (v_sync !== exp_next) begin
                    failures++;
                    $display("FAIL next_vsync fc=%0d: v_sync=%b required %b", exp_fc, v_sync, exp_next);
                end
            end
            if (i == drop_at) enable = 1'b0;
        end
        checks++;
        if (vs_cnt != L_SLOTS) begin
            failures++;
            $display("FAIL vsync_len fc=%0d: %0d slots required %0d", exp_fc, vs_cnt, L_SLOTS);
        end
        checks++;
        if (hr_pulses != 2) begin
            failures++;
            $display("FAIL href_pulses fc=%0d: %0d required 2", exp_fc, hr_pulses);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_25);
        checks++;
        if ({pclk, v_sync, h_ref, data_out, frame_done, frame_count} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state: pclk=%b vs=%b hr=%b data=%h fd=%b fc=%0d required all 0",
                     pclk, v_sync, h_ref, data_out, frame_done, frame_count);
        end
        reset_n = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk_25);
            checks++;
            if (pclk !== ((j % 2) == 1) || v_sync !== 1'b0 || h_ref !== 1'b0 ||
                data_out !== 8'h00 || frame_done !== 1'b0 || frame_count !== 8'd0) begin
                failures++;
                $display("FAIL idle j=%0d: pclk=%b vs=%b hr=%b data=%h fd=%b fc=%0d required pclk=%b rest 0",
                         j, pclk, v_sync, h_ref, data_out, frame_done, frame_count, (j % 2) == 1);
            end
        end
    endtask

    task automatic test_first_frame();
        enable = 1'b1;
        capture_frame(1, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        capture_frame(2, -1, 1'b1);
        checks++;
`ifdef CAM_STREAM_SCROLL_EN
        if (first_b0 !== 8'hFF || first_b1 !== 8'hE0) begin
            failures++;
            $display("FAIL scroll_first_bytes: %h %h required FF E0", first_b0, first_b1);
        end
`else
        if (first_b0 !== 8'hFF || first_b1 !== 8'hFF) begin
            failures++;
            $display("FAIL static_first_bytes: %h %h required FF FF", first_b0, first_b1);
        end
`endif
        capture_frame(3, -1, 1'b1);
    endtask

    task automatic test_enable_drop();
        // i=124 is slot 62, mid second active line
        capture_frame(4, 124, 1'b0);
        for (int j = 0; j < 300; j++) begin
            @(negedge clk_25);
            checks++;
            if (v_sync !== 1'b0 || h_ref !== 1'b0 || frame_done !== 1'b0 || frame_count !== 8'd4) begin
                failures++;
                $display("FAIL idle_after_drop j=%0d: vs=%b hr=%b fd=%b fc=%0d required 0 0 0 4",
                         j, v_sync, h_ref, frame_done, frame_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        enable = 1'b1;
        while (h_ref !== 1'b1 && waited < 300) begin
            @(negedge clk_25);
            waited++;
        end
        checks++;
        if (h_ref !== 1'b1) begin
            failures++;
            $display("FAIL href_before_reset: h_ref=%b required 1 within 300 cycles", h_ref);
        end
        repeat (3) @(negedge clk_25);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pclk, v_sync, h_ref, data_out, frame_done, frame_count} !== 20'h0) begin
            failures++;
            $display("FAIL async_reset: pclk=%b vs=%b hr=%b data=%h fd=%b fc=%0d required all 0",
                     pclk, v_sync, h_ref, data_out, frame_done, frame_count);
        end
        repeat (4) @(negedge clk_25);
        reset_n = 1'b1;
        capture_frame(1, -1, 1'b1);
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
